// File: rtl/alu_mc_if.sv
// Operand/result bus of the multi-cycle ALU: launch controls toward the ALU,
// registered result, handshake and status flags back to the requester.
interface alu_mc_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             start;
  logic             en_flag;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             busy;
  logic             done;
  logic             zero;
  logic             carry;
  logic             negative;
  logic             overflow;

  modport master (
    output a, b, op, start, en_flag,
    input  result, result_hi, busy, done, zero, carry, negative, overflow
  );

  modport slave (
    input  a, b, op, start, en_flag,
    output result, result_hi, busy, done, zero, carry, negative, overflow
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle add/sub/logic/shift ops plus a WIDTH-cycle
// unsigned shift-add multiply, registered result and zero/carry/negative/
// overflow status flags. Carry feeds back into ADC/SBC for multi-word math.
module alu_mc #(
  parameter int WIDTH = 8
) (
  input  logic    clock,
  input  logic    reset_n,
  alu_mc_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_ADC = 4'd2,
    OP_SBC = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_XOR = 4'd6,
    OP_SHL = 4'd7,
    OP_SHR = 4'd8,
    OP_MUL = 4'd9
  } op_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               men_q, men_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               done_q, done_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;
  logic               neg_q, neg_d;
  logic               ovf_q, ovf_d;

  logic [WIDTH-1:0]   add_b;
  logic               add_cin;
  logic [WIDTH:0]     add_sum;
  logic               add_v;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic [2*WIDTH-1:0] step_prod;

  // State and datapath registers; reset aborts any multiply in flight
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      men_q    <= 1'b0;
      result_q <= '0;
      hi_q     <= '0;
      done_q   <= 1'b0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      men_q    <= men_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      done_q   <= done_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next state: MUL is entered from an accepted start and left after the last iteration
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start && (bus.op == OP_MUL)) state_d = S_MUL;
      S_MUL:   if (cnt_q <= CW'(1)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Single-cycle ALU; SUB/SBC reuse the adder with inverted B
  always_comb begin
    add_b   = bus.b;
    add_cin = 1'b0;
    case (bus.op)
      OP_SUB:  begin add_b = ~bus.b; add_cin = 1'b1;    end
      OP_ADC:  begin add_b = bus.b;  add_cin = carry_q; end
      OP_SBC:  begin add_b = ~bus.b; add_cin = carry_q; end
      default: ;
    endcase
    add_sum = {1'b0, bus.a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    add_v   = (bus.a[WIDTH-1] == add_b[WIDTH-1]) &&
              (add_sum[WIDTH-1] != bus.a[WIDTH-1]);

    alu_res = bus.a;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.op)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
        alu_res = add_sum[WIDTH-1:0];
        alu_c   = add_sum[WIDTH];
        alu_v   = add_v;
      end
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_SHL: begin
        alu_res = {bus.a[WIDTH-2:0], 1'b0};
        alu_c   = bus.a[WIDTH-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, bus.a[WIDTH-1:1]};
        alu_c   = bus.a[0];
      end
      default: alu_res = bus.a;
    endcase
  end

  // One shift-add step: accumulate the multiplicand when the multiplier LSB is set
  always_comb begin
    step_prod = prod_q + (mplier_q[0] ? mcand_q : '0);
  end

  // Output/datapath updates: launch, multiply iteration, result and flag writes
  always_comb begin
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    men_d    = men_q;
    result_d = result_q;
    hi_d     = hi_q;
    done_d   = 1'b0;
    zero_d   = zero_q;
    carry_d  = carry_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.op == OP_MUL) begin
            mcand_d  = {{WIDTH{1'b0}}, bus.a};
            mplier_d = bus.b;
            prod_d   = '0;
            men_d    = bus.en_flag;
            cnt_d    = CW'(WIDTH);
          end else begin
            result_d = alu_res;
            hi_d     = '0;
            done_d   = 1'b1;
            if (bus.en_flag) begin
              zero_d  = (alu_res == '0);
              carry_d = alu_c;
              neg_d   = alu_res[WIDTH-1];
              ovf_d   = alu_v;
            end
          end
        end
      end
      S_MUL: begin
        prod_d   = step_prod;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) begin
          result_d = step_prod[WIDTH-1:0];
          hi_d     = step_prod[2*WIDTH-1:WIDTH];
          done_d   = 1'b1;
          if (men_q) begin
            zero_d  = (step_prod == '0);
            carry_d = |step_prod[2*WIDTH-1:WIDTH];
            neg_d   = step_prod[WIDTH-1];
            ovf_d   = |step_prod[2*WIDTH-1:WIDTH];
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.result    = result_q;
  assign bus.result_hi = hi_q;
  assign bus.busy      = (state_q == S_MUL);
  assign bus.done      = done_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign bus.negative  = neg_q;
  assign bus.overflow  = ovf_q;

endmodule
